// File: rtl/req_priority_arbiter.sv
// ============================================================================
// Module  : req_priority_arbiter
// Brief   : 8-requester arbiter, fixed (bit 7 highest) or round-robin pick,
//           registered hold-while-requesting grants bounded by MAX_HOLD.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module req_priority_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [2:0]       r_last_id, w_last_nxt;
  logic [7:0]       w_grant_nxt;
  logic [2:0]       w_id_nxt;
  logic             w_valid_nxt;
  logic             w_preempt_nxt;
  logic [7:0]       w_others;
  logic [7:0]       w_cand;
  logic [2:0]       w_win;
  logic             w_owner_req;

  // Round-robin walks downward from last-1 and ends at last itself; iterating
  // from the farthest distance lets the nearest hit overwrite earlier ones.
  function automatic logic [2:0] pick(input logic [7:0] c, input logic rr,
                                      input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] j;
    idx = '0;
    if (rr) begin
      for (int k = 8; k >= 1; k--) begin
        j = last - 3'(k);
        if (c[j]) idx = j;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (c[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  assign w_owner_req = req[grant_id];
  assign w_others    = req & ~grant;
  // While the owner still requests, only a hold expiry arbitrates, and then
  // the owner is excluded from the candidates.
  assign w_cand      = (r_state == BUSY && w_owner_req) ? w_others : req;
  assign w_win       = pick(w_cand, mode, r_last_id);

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_last_nxt    = r_last_id;
    w_grant_nxt   = grant;
    w_id_nxt      = grant_id;
    w_valid_nxt   = grant_valid;
    w_preempt_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 8'd0) begin
          w_state_nxt = BUSY;
          w_grant_nxt = 8'b1 << w_win;
          w_id_nxt    = w_win;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
          w_last_nxt  = w_win;
        end
      end
      BUSY: begin
        if (w_owner_req) begin
          if (r_hold_cnt == c_hold_last) begin
            w_hold_nxt = '0;
            if (w_others != 8'd0) begin
              w_grant_nxt   = 8'b1 << w_win;
              w_id_nxt      = w_win;
              w_last_nxt    = w_win;
              w_preempt_nxt = 1'b1;
            end
          end else begin
            w_hold_nxt = r_hold_cnt + CNT_W'(1);
          end
        end else if (req != 8'd0) begin
          w_grant_nxt = 8'b1 << w_win;
          w_id_nxt    = w_win;
          w_last_nxt  = w_win;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = 8'd0;
          w_id_nxt    = 3'd0;
          w_valid_nxt = 1'b0;
          w_hold_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_cnt  <= '0;
      r_last_id   <= 3'd0;
      grant       <= 8'd0;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_last_id   <= w_last_nxt;
      grant       <= w_grant_nxt;
      grant_id    <= w_id_nxt;
      grant_valid <= w_valid_nxt;
      preempt     <= w_preempt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_priority_arbiter.sv
// ============================================================================
// Module  : tb_req_priority_arbiter
// Brief   : Directed plus randomized bench for req_priority_arbiter against a
//           behavioural owner/hold/last-pick model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_priority_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       preempt;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: owner index (-1 when idle), cycles held, last winner.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = 0;
  bit m_pre   = 1'b0;

  req_priority_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  always #5 clk = ~clk;

  function automatic int arb(input logic [7:0] c, input bit rr, input int last);
    int idx;
    if (rr) begin
      for (int d = 1; d <= 8; d++) begin
        idx = (last - d + 16) % 8;
        if (c[idx]) return idx;
      end
    end else begin
      for (int i = 7; i >= 0; i--) if (c[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 0;
    m_pre   = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] r, input bit md);
    logic [7:0] others;
    int w;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      w = arb(r, md, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hold  = 0;
      end
    end else if (r[m_owner]) begin
      if (m_hold == MAX_HOLD - 1) begin
        others          = r;
        others[m_owner] = 1'b0;
        w = arb(others, md, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_pre   = 1'b1;
        end
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end else begin
      w = arb(r, md, m_last);
      m_owner = w;
      m_hold  = 0;
      if (w >= 0) m_last = w;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"}, grant, (m_owner < 0) ? 8'd0 : (8'd1 << m_owner));
    chk({tag, ".grant_id"}, {5'd0, grant_id}, (m_owner < 0) ? 8'd0 : 8'(m_owner));
    chk({tag, ".grant_valid"}, {7'd0, grant_valid}, {7'd0, (m_owner >= 0)});
    chk({tag, ".preempt"}, {7'd0, preempt}, {7'd0, m_pre});
  endtask

  // One clock: model consumes the inputs seen at the edge, DUT is sampled at
  // the following falling edge.
  task automatic cycle(input string tag);
    model_step(req, mode);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    req   = 8'd0;
    mode  = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle");

    // Lower owner keeps grant against a higher request until hold expiry.
    req = 8'b0000_0101;
    cycle("first");
    chk("first_id_is_2", {5'd0, grant_id}, 8'd2);
    req = 8'b1000_0101;
    run("hold_vs_high", MAX_HOLD + 4);
    chk("expired_to_7", grant, 8'h80);

    req = 8'd0;
    run("drain", 2);
    req = 8'hFF;
    run("fixed_ff", 3 * MAX_HOLD + 2);

    req = 8'd0;
    run("drain", 2);
    mode = 1'b1;
    req  = 8'hFF;
    run("rr_ff", 9 * MAX_HOLD + 2);

    req  = 8'd0;
    mode = 1'b0;
    run("drain", 2);
    req = 8'h08;
    cycle("own3");
    req = 8'h0A;
    run("own3_with_1", 3);
    req = 8'h02;
    cycle("handoff");
    chk("handoff_id_1", {5'd0, grant_id}, 8'd1);
    req = 8'h00;
    cycle("to_idle");
    chk("idle_valid", {7'd0, grant_valid}, 8'd0);

    req = 8'h10;
    run("single_4", 40);

    // Randomized segments: random request vector held for a random length.
    for (int s = 0; s < 40; s++) begin
      req  = 8'($urandom);
      mode = 1'($urandom_range(1));
      len  = $urandom_range(1, 24);
      run("rand", len);
    end

    // Asynchronous reset between edges clears outputs without a clock.
    mode = 1'b1;
    req  = 8'h30;
    run("pre_rst", 5);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h01;
    cycle("post_rst");
    chk("post_rst_grant", grant, 8'h01);
    req = 8'h81;
    run("post_rst_rr", 2 * MAX_HOLD + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
